sdram_test_sequencer: RTL and testbench
=======================================

Name: sdram_test_sequencer

Overview:
- Self-test sequencer for the SDRAM controller's host-side FIFO port pair (WR1/RD1), running in the clk_27m domain.
- On `start` it:
  - writes NUM_WORDS pattern words through the write FIFO;
  - waits for the controller to flush them to SDRAM;
  - reloads the read FIFO and reads the words back;
  - compares each word against a regenerated pattern.
- Reports pass/fail, error count and first failing index, for display on the segment decoders.

Parameters:
- NUM_WORDS, 16: words per test pass; range 1..255.
- IDX_W, 8: index/counter width; NUM_WORDS must be ≤ 2**IDX_W-1.
- WAIT_CYC, 64: idle cycles after the last write before the read phase (controller flush time).
- RD_LAT, 1: cycles from `rd_en` high to valid `rd_data`; range 0..3.
- LOAD_CYC, 2: cycles `wr_load`/`rd_load` are held high.

Ports:
- clk_27m  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; ignored unless state is IDLE or DONE
- seed  in  16  pattern seed, captured on an accepted `start`
- wr_data  out  16  write FIFO data
- wr_en  out  1  write FIFO strobe, one word per high cycle
- wr_load  out  1  write-address reload to the controller
- rd_en  out  1  read FIFO strobe, one word per high cycle
- rd_load  out  1  read-address reload / read FIFO flush to the controller
- rd_data  in  16  read FIFO data
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- pass  out  1  valid while `done`=1; 1 iff err_cnt==0
- err_cnt  out  8  mismatch count, saturating at 255
- first_err  out  IDX_W  index of the first mismatch; 0 if none

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0, including wr_data, err_cnt and first_err. Index and delay counters 0.
- All outputs are registered.
- States and transitions:
  - IDLE / DONE: on `start` → WLOAD. Capture `seed`; clear err_cnt, first_err and the error flag.
  - WLOAD: wr_load=1 for LOAD_CYC cycles → WRITE.
  - WRITE: wr_en=1 for exactly NUM_WORDS consecutive cycles.
    - wr_data = pattern(i), i = 0..NUM_WORDS-1.
    - After the last word → WAIT.
  - WAIT: count WAIT_CYC cycles with no strobes → RLOAD.
  - RLOAD: rd_load=1 for LOAD_CYC cycles → READ.
  - READ: rd_en=1 for exactly NUM_WORDS cycles → DRAIN.
  - DRAIN: wait RD_LAT cycles so every response is sampled → DONE.
  - DONE: done=1 and pass valid; held until the next `start` or `rst`.
- Pattern:
  - pattern(i) = seed + i, modulo 2^16 (wrap at 16'hFFFF→0).
  - The expected value is regenerated through an RD_LAT-deep pipeline of the index alongside the `rd_en` strobes.
- Compare: when a delayed strobe emerges, if rd_data ≠ expected:
  - err_cnt increments, saturating at 255;
  - on the first mismatch only, first_err takes that index.
- `start` while busy: ignored, no effect.
- `start` in DONE: restarts the test; done drops the next cycle.
- wr_load, wr_en, rd_load and rd_en are mutually exclusive; never two high in the same cycle.
- `rst` mid-test: immediate return to IDLE with all strobes low. The controller FIFO contents are then undefined; the next run reloads both FIFOs, so no recovery logic is required.
- NUM_WORDS=1: WRITE and READ each last one cycle.

Optional Feature:
- Macro: SDRAM_TEST_SEQ_LFSR_EN.
- Defined: pattern(0)=seed, or 16'h0001 if seed==0. Each subsequent word is the 16-bit Galois LFSR step with taps 16'hB400. The expected stream uses an identical second LFSR, advanced only on delayed read strobes.
- Undefined: incrementing pattern as above; no LFSR logic present.

Decomposition:
- Package sdram_test_pkg holds:
  - the state enum (IDLE, WLOAD, WRITE, WAIT, RLOAD, READ, DRAIN, DONE);
  - LFSR_TAPS = 16'hB400;
  - ERR_SAT = 8'd255.
- One sub-module: sdram_pattern_gen, with seed load, an advance strobe and 16-bit output.
  - Behaviour is incrementing or LFSR per the macro.
  - Instantiated twice: once for write data, once for expected data.

Test Plan:
- Loopback model (RD_LAT=1), seed=16'h0000, NUM_WORDS=16, start →
  - wr_en high for 16 cycles with data 0..15;
  - done=1, pass=1, err_cnt=0, first_err=0.
- seed=16'hFFF8 →
  - wr_data runs FFF8..FFFF, then 0000..0007;
  - pass=1.
- Model corrupts the word at index 5 (XOR 16'h0100) → pass=0, err_cnt=1, first_err=5.
- Model returns all-zero data with seed=16'h1000 → err_cnt=16, first_err=0.
  - Additional saturation run: NUM_WORDS=255, IDX_W=9, seed=1, all-zero data, then force further mismatches → err_cnt holds at 255.
- Assert rst=1 midway through WRITE (word 7) →
  - all strobes low asynchronously, busy=0;
  - a new start then produces a full 16-word run with pass=1.
- start pulsed during READ → ignored; cycle counts unchanged. start in DONE → new run, done low next cycle.
- With SDRAM_TEST_SEQ_LFSR_EN and seed=0 → first word 16'h0001, second 16'hB400; pass=1 on loopback.

Source files
------------

// File: rtl/sdram_test_pkg.sv
// Shared types and constants for the SDRAM FIFO-port self-test sequencer.
// Optional LFSR pattern mode is selected with the SDRAM_TEST_SEQ_LFSR_EN macro.
package sdram_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        WRITE,
        WAIT,
        RLOAD,
        READ,
        DRAIN,
        DONE
    } seq_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [7:0]  ERR_SAT   = 8'd255;

    // One right-shifting Galois LFSR step.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Test pattern source: loads a seed, then steps once per advance strobe.
// Incrementing by default; 16-bit Galois LFSR when SDRAM_TEST_SEQ_LFSR_EN is defined.
module sdram_pattern_gen
    import sdram_test_pkg::*;
(
    input  logic        clk_27m,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] pattern
);

    // Pattern register: load has priority over advance.
    always_ff @(posedge clk_27m or posedge rst) begin
        if (rst) begin
            pattern <= 16'h0000;
        end else if (load) begin
`ifdef SDRAM_TEST_SEQ_LFSR_EN
            // An all-zero LFSR state would lock up, so substitute 1.
            pattern <= (seed == 16'h0000) ? 16'h0001 : seed;
`else
            pattern <= seed;
`endif
        end else if (advance) begin
`ifdef SDRAM_TEST_SEQ_LFSR_EN
            pattern <= lfsr_step(pattern);
`else
            pattern <= pattern + 16'd1;
`endif
        end
    end

endmodule

// File: rtl/sdram_test_sequencer.sv
// SDRAM WR1/RD1 FIFO-port self-test: write a pattern, wait for flush,
// read it back and compare. Pattern style set by SDRAM_TEST_SEQ_LFSR_EN.
module sdram_test_sequencer
    import sdram_test_pkg::*;
#(
    parameter int NUM_WORDS = 16,
    parameter int IDX_W     = 8,
    parameter int WAIT_CYC  = 64,
    parameter int RD_LAT    = 1,
    parameter int LOAD_CYC  = 2
) (
    input  logic             clk_27m,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      seed,
    output logic [15:0]      wr_data,
    output logic             wr_en,
    output logic             wr_load,
    output logic             rd_en,
    output logic             rd_load,
    input  logic [15:0]      rd_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_cnt,
    output logic [IDX_W-1:0] first_err
);

    localparam int               DLY_W      = 16;
    localparam int               SR_LEN     = (RD_LAT > 0) ? RD_LAT : 1;
    localparam logic [DLY_W-1:0] DLY_ONE    = DLY_W'(1);
    localparam logic [DLY_W-1:0] LOAD_INIT  = DLY_W'(LOAD_CYC - 1);
    localparam logic [DLY_W-1:0] WAIT_INIT  = DLY_W'(WAIT_CYC - 1);
    localparam logic [DLY_W-1:0] DRAIN_INIT = DLY_W'(SR_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_WORDS - 1);

    seq_state_t       state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [DLY_W-1:0] dly, dly_nxt;
    logic             err_flag, err_flag_nxt;
    logic [7:0]       err_cnt_nxt;
    logic [IDX_W-1:0] first_err_nxt;
    logic             start_ok;
    logic [15:0]      exp_data;
    logic             cmp_vld;
    logic [IDX_W-1:0] cmp_idx;
    logic [SR_LEN-1:0] vld_sr;
    logic [IDX_W-1:0] idx_sr [SR_LEN];
    logic             wr_load_d, wr_en_d, rd_load_d, rd_en_d;
    logic             busy_d, done_d, pass_d;

    assign start_ok = start && (state == IDLE || state == DONE);

    // The write generator drives wr_data straight from its register.
    sdram_pattern_gen u_wr_gen (
        .clk_27m (clk_27m),
        .rst     (rst),
        .load    (start_ok),
        .seed    (seed),
        .advance (state == WRITE),
        .pattern (wr_data)
    );

    // The expected generator follows the delayed read strobes only.
    sdram_pattern_gen u_exp_gen (
        .clk_27m (clk_27m),
        .rst     (rst),
        .load    (start_ok),
        .seed    (seed),
        .advance (cmp_vld),
        .pattern (exp_data)
    );

    assign cmp_vld = (RD_LAT == 0) ? rd_en : vld_sr[SR_LEN-1];
    assign cmp_idx = (RD_LAT == 0) ? idx   : idx_sr[SR_LEN-1];

    // Read-strobe and index delay line, matching the FIFO read latency.
    always_ff @(posedge clk_27m or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
            for (int k = 0; k < SR_LEN; k++) idx_sr[k] <= '0;
        end else begin
            vld_sr[0] <= rd_en;
            idx_sr[0] <= idx;
            for (int k = 1; k < SR_LEN; k++) begin
                vld_sr[k] <= vld_sr[k-1];
                idx_sr[k] <= idx_sr[k-1];
            end
        end
    end

    // State, counters and all outputs are registered together.
    always_ff @(posedge clk_27m or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            dly       <= '0;
            err_flag  <= 1'b0;
            err_cnt   <= 8'd0;
            first_err <= '0;
            wr_load   <= 1'b0;
            wr_en     <= 1'b0;
            rd_load   <= 1'b0;
            rd_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            dly       <= dly_nxt;
            err_flag  <= err_flag_nxt;
            err_cnt   <= err_cnt_nxt;
            first_err <= first_err_nxt;
            wr_load   <= wr_load_d;
            wr_en     <= wr_en_d;
            rd_load   <= rd_load_d;
            rd_en     <= rd_en_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        dly_nxt   = dly;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = WLOAD;
                    dly_nxt   = LOAD_INIT;
                end
            end
            WLOAD: begin
                if (dly == '0) begin
                    state_nxt = WRITE;
                    idx_nxt   = '0;
                end else begin
                    dly_nxt = dly - DLY_ONE;
                end
            end
            WRITE: begin
                if (idx == IDX_LAST) begin
                    state_nxt = WAIT;
                    dly_nxt   = WAIT_INIT;
                end else begin
                    idx_nxt = idx + IDX_ONE;
                end
            end
            WAIT: begin
                if (dly == '0) begin
                    state_nxt = RLOAD;
                    dly_nxt   = LOAD_INIT;
                end else begin
                    dly_nxt = dly - DLY_ONE;
                end
            end
            RLOAD: begin
                if (dly == '0) begin
                    state_nxt = READ;
                    idx_nxt   = '0;
                end else begin
                    dly_nxt = dly - DLY_ONE;
                end
            end
            READ: begin
                if (idx == IDX_LAST) begin
                    // With zero latency the last word is compared in READ itself.
                    state_nxt = (RD_LAT == 0) ? DONE : DRAIN;
                    dly_nxt   = DRAIN_INIT;
                end else begin
                    idx_nxt = idx + IDX_ONE;
                end
            end
            DRAIN: begin
                if (dly == '0) begin
                    state_nxt = DONE;
                end else begin
                    dly_nxt = dly - DLY_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Error accounting: saturating count, first failing index latched once.
    always_comb begin
        err_cnt_nxt   = err_cnt;
        first_err_nxt = first_err;
        err_flag_nxt  = err_flag;
        if (start_ok) begin
            err_cnt_nxt   = 8'd0;
            first_err_nxt = '0;
            err_flag_nxt  = 1'b0;
        end else if (cmp_vld && (rd_data != exp_data)) begin
            if (err_cnt != ERR_SAT) err_cnt_nxt = err_cnt + 8'd1;
            if (!err_flag) begin
                first_err_nxt = cmp_idx;
                err_flag_nxt  = 1'b1;
            end
        end
    end

    // Output decode from the next state so every output comes off a flop.
    always_comb begin
        wr_load_d = (state_nxt == WLOAD);
        wr_en_d   = (state_nxt == WRITE);
        rd_load_d = (state_nxt == RLOAD);
        rd_en_d   = (state_nxt == READ);
        busy_d    = (state_nxt != IDLE) && (state_nxt != DONE);
        done_d    = (state_nxt == DONE);
        pass_d    = (state_nxt == DONE) && (err_cnt_nxt == 8'd0);
    end

endmodule

// File: tb/tb_sdram_test_sequencer.sv
// Directed bench for sdram_test_sequencer with a loopback FIFO model.
// Also builds with SDRAM_TEST_SEQ_LFSR_EN to cover the LFSR pattern.
module tb_sdram_test_sequencer;

    logic        clk_27m = 1'b0;
    logic        rst;
    logic        start;
    logic        sat_start;
    logic [15:0] seed;
    logic [15:0] wr_data;
    logic        wr_en, wr_load, rd_en, rd_load;
    logic [15:0] rd_data = 16'h0000;
    logic        busy, done, pass;
    logic [7:0]  err_cnt;
    logic [7:0]  first_err;

    logic [15:0] s_wr_data;
    logic        s_wr_en, s_wr_load, s_rd_en, s_rd_load;
    logic        s_busy, s_done, s_pass;
    logic [7:0]  s_err_cnt;
    logic [8:0]  s_first_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          mode = 0;
    int          wr_cnt = 0, rd_cnt = 0, busy_cyc = 0, excl_viol = 0;
    int          b_wr, b_rd, b_busy;

    always #5 clk_27m = ~clk_27m;

    sdram_test_sequencer #(
        .NUM_WORDS(16), .IDX_W(8), .WAIT_CYC(64), .RD_LAT(1), .LOAD_CYC(2)
    ) u_dut (
        .clk_27m(clk_27m), .rst(rst), .start(start), .seed(seed),
        .wr_data(wr_data), .wr_en(wr_en), .wr_load(wr_load),
        .rd_en(rd_en), .rd_load(rd_load), .rd_data(rd_data),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err(first_err)
    );

    sdram_test_sequencer #(
        .NUM_WORDS(255), .IDX_W(9), .WAIT_CYC(64), .RD_LAT(1), .LOAD_CYC(2)
    ) u_sat (
        .clk_27m(clk_27m), .rst(rst), .start(sat_start), .seed(seed),
        .wr_data(s_wr_data), .wr_en(s_wr_en), .wr_load(s_wr_load),
        .rd_en(s_rd_en), .rd_load(s_rd_load), .rd_data(16'h0000),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_cnt(s_err_cnt), .first_err(s_first_err)
    );

    function automatic logic [15:0] model_word(input int p);
        logic [15:0] w;
        w = mem[p[7:0]];
        if (mode == 1 && p == 5) w = w ^ 16'h0100;
        if (mode == 2) w = 16'h0000;
        return w;
    endfunction

    function automatic logic [15:0] exp_pat(input logic [15:0] s, input int i);
        logic [15:0] v;
`ifdef SDRAM_TEST_SEQ_LFSR_EN
        v = (s == 16'h0000) ? 16'h0001 : s;
        for (int k = 0; k < i; k++) v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
`else
        v = s + 16'(i);
`endif
        return v;
    endfunction

    // Loopback FIFO model with one cycle of read latency, plus activity counters.
    always @(posedge clk_27m) begin
        if (wr_load) wr_ptr <= 0;
        else if (wr_en) begin
            mem[wr_ptr[7:0]] <= wr_data;
            wr_ptr <= wr_ptr + 1;
        end
        if (rd_load) rd_ptr <= 0;
        else if (rd_en) begin
            rd_data <= model_word(rd_ptr);
            rd_ptr <= rd_ptr + 1;
        end
        if (wr_en) wr_cnt <= wr_cnt + 1;
        if (rd_en) rd_cnt <= rd_cnt + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
        if ((int'(wr_load) + int'(wr_en) + int'(rd_load) + int'(rd_en)) > 1)
            excl_viol <= excl_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk_27m);
        start = 1'b1;
        @(negedge clk_27m);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk_27m);
            n++;
        end
        check(tag, done, 1'b1);
    endtask

    task automatic run(input logic [15:0] s, input int m, input string tag);
        seed = s;
        mode = m;
        b_wr = wr_cnt;
        b_rd = rd_cnt;
        b_busy = busy_cyc;
        pulse_start();
        wait_done(tag);
    endtask

    task automatic check_seq(input string tag, input logic [15:0] s);
        int bad;
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== exp_pat(s, i)) bad++;
        check(tag, bad, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        sat_start = 1'b0;
        seed = 16'h0000;
        repeat (3) @(negedge clk_27m);
        check("rst_strobes", {wr_load, wr_en, rd_load, rd_en}, 4'b0000);
        check("rst_status", {busy, done, pass}, 3'b000);
        check("rst_wr_data", wr_data, 16'h0000);
        check("rst_err", {err_cnt, first_err}, 16'h0000);
        rst = 1'b0;

        // Seed 0 loopback
        run(16'h0000, 0, "run0_done");
        check("run0_pass", pass, 1'b1);
        check("run0_err", {err_cnt, first_err}, 16'h0000);
        check("run0_wr_cnt", wr_cnt - b_wr, 16);
        check("run0_rd_cnt", rd_cnt - b_rd, 16);
        check("run0_busy_cyc", busy_cyc - b_busy, 101);
        check_seq("run0_seq", 16'h0000);
`ifdef SDRAM_TEST_SEQ_LFSR_EN
        check("lfsr_w0", mem[0], 16'h0001);
        check("lfsr_w1", mem[1], 16'hB400);
`else
        check("run0_w0", mem[0], 16'h0000);
        check("run0_w15", mem[15], 16'h000F);
`endif

        // Wrap-around seed
        run(16'hFFF8, 0, "wrap_done");
        check("wrap_pass", pass, 1'b1);
        check_seq("wrap_seq", 16'hFFF8);
`ifndef SDRAM_TEST_SEQ_LFSR_EN
        check("wrap_w0", mem[0], 16'hFFF8);
        check("wrap_w7", mem[7], 16'hFFFF);
        check("wrap_w8", mem[8], 16'h0000);
        check("wrap_w15", mem[15], 16'h0007);
`endif

        // Single corrupted word at index 5
        run(16'h1234, 1, "corr_done");
        check("corr_pass", pass, 1'b0);
        check("corr_err_cnt", err_cnt, 8'd1);
        check("corr_first", first_err, 8'd5);

        // All-zero read data
        run(16'h1000, 2, "zero_done");
        check("zero_pass", pass, 1'b0);
        check("zero_err_cnt", err_cnt, 8'd16);
        check("zero_first", first_err, 8'd0);

        // Reset in the middle of WRITE at word 7
        seed = 16'h0300;
        mode = 0;
        pulse_start();
        n = 0;
        while (!(wr_en && wr_ptr == 7) && n < 200) begin
            @(negedge clk_27m);
            n++;
        end
        check("midrst_reach", wr_en, 1'b1);
        check("midrst_word7", wr_data, exp_pat(16'h0300, 7));
        rst = 1'b1;
        #1;
        check("midrst_strobes", {wr_load, wr_en, rd_load, rd_en}, 4'b0000);
        check("midrst_busy", {busy, done}, 2'b00);
        @(negedge clk_27m);
        rst = 1'b0;
        run(16'h0042, 0, "after_rst_done");
        check("after_rst_pass", pass, 1'b1);
        check("after_rst_wr_cnt", wr_cnt - b_wr, 16);
        check_seq("after_rst_seq", 16'h0042);

        // start pulsed during READ is ignored
        seed = 16'h5555;
        mode = 0;
        b_wr = wr_cnt;
        b_rd = rd_cnt;
        b_busy = busy_cyc;
        pulse_start();
        n = 0;
        while (!rd_en && n < 200) begin
            @(negedge clk_27m);
            n++;
        end
        check("rd_reach", rd_en, 1'b1);
        start = 1'b1;
        @(negedge clk_27m);
        start = 1'b0;
        wait_done("busy_start_done");
        check("busy_start_cyc", busy_cyc - b_busy, 101);
        check("busy_start_rd_cnt", rd_cnt - b_rd, 16);
        check("busy_start_pass", pass, 1'b1);

        // start in DONE restarts; done drops next cycle
        seed = 16'h00A0;
        pulse_start();
        check("restart_done_low", {done, busy}, 2'b01);
        wait_done("restart_done");
        check("restart_pass", pass, 1'b1);
        check_seq("restart_seq", 16'h00A0);

        check("strobe_exclusive", excl_viol, 0);

        // Saturation: 255 words, all mismatching
        seed = 16'h0001;
        @(negedge clk_27m);
        sat_start = 1'b1;
        @(negedge clk_27m);
        sat_start = 1'b0;
        n = 0;
        while (!s_done && n < 3000) begin
            @(negedge clk_27m);
            n++;
        end
        check("sat_done", s_done, 1'b1);
        check("sat_err_cnt", s_err_cnt, 8'd255);
        check("sat_first", s_first_err, 9'd0);
        check("sat_pass", s_pass, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
